vga_timing_gen: RTL and testbench

//  Raster timing generator for the DE2 VGA path (50 MHz clk -> ADV7123 DAC).

---
 rtl/vga_timing_gen_pkg.sv | 39 +++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen_dly_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants and small helpers for the VGA timing
// generator and the downstream pattern/colour stage.
package vga_timing_gen_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Raster flags, active-high internally; polarity is applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

    // True when counter c lies in the half-open window [lo, hi).
    function automatic logic in_window(input cnt_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the timing generator to the colour stage / DAC pins.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic pix_ce;
    logic vga_clk;
    cnt_t x;
    cnt_t y;
    logic de;
    logic line_start;
    logic frame_start;
    logic hsync;
    logic vsync;
    logic blank_n;
    logic sync_n;

    modport master (
        output pix_ce, vga_clk, x, y, de, line_start, frame_start,
               hsync, vsync, blank_n, sync_n
    );

    modport slave (
        input pix_ce, vga_clk, x, y, de, line_start, frame_start,
              hsync, vsync, blank_n, sync_n
    );

endinterface

// File: rtl/vga_timing_gen_dly_line.sv
// Clock-enable gated shift register with synchronous reset to INIT.
// Aligns sync/blank with the colour stage's pixel latency.
module vga_dly_line #(
    parameter int             W     = 1,
    parameter int             DEPTH = 1,
    parameter logic [W-1:0]   INIT  = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    // Flush to INIT on reset; otherwise shift one stage per enabled clock.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= INIT;
            end
        end else if (ce_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, raster decode,
// and sync/blank outputs delayed to match the colour stage latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_gen_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_gen_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_gen_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_gen_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_gen_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_gen_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_gen_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_gen_pkg::V_BP,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    vga_timing_gen_if.master    vid_o
);
    import vga_timing_gen_pkg::*;

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    localparam int             DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam cnt_t           H_LAST   = cnt_t'(H_TOT - 1);
    localparam cnt_t           V_LAST   = cnt_t'(V_TOT - 1);

    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
            $error("vga_timing_gen: H/V total exceeds 10-bit counter range");
        end
        if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be even and >= 2");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be 0..7");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    cnt_t             hcnt_q, hcnt_d;
    cnt_t             vcnt_q, vcnt_d;
    logic             vga_clk_q, vga_clk_d;
    logic             pix_ce;
    logic             de_now;
    vga_flags_t       flags_q, flags_d;
    vga_flags_t       flags_dly;

    // Next divider/counter state and the raster decode of the next position.
    always_comb begin
        pix_ce    = (div_cnt_q == DIV_LAST);
        div_cnt_d = pix_ce ? '0 : div_cnt_q + 1'b1;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        if (pix_ce) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
        // Registered so the DAC clock comes straight off a flop.
        vga_clk_d  = (div_cnt_d >= DIV_HALF);
        flags_d.hs = in_window(hcnt_d, HS_BEG, HS_END);
        flags_d.vs = in_window(vcnt_d, VS_BEG, VS_END);
        flags_d.de = in_window(hcnt_d, 0, H_ACTIVE) && in_window(vcnt_d, 0, V_ACTIVE);
        de_now     = in_window(hcnt_q, 0, H_ACTIVE) && in_window(vcnt_q, 0, V_ACTIVE);
    end

    // Divider, counters, DAC clock and the pixel-aligned raw decode register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vga_clk_q <= 1'b0;
            flags_q   <= FLAGS_IDLE;
        end else begin
            div_cnt_q <= div_cnt_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            vga_clk_q <= vga_clk_d;
            flags_q   <= flags_d;
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign flags_dly = flags_q;
        end else begin : g_dly
            vga_dly_line #(
                .W     ($bits(vga_flags_t)),
                .DEPTH (PIPE_DLY),
                .INIT  (FLAGS_IDLE)
            ) u_dly (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .ce_i    (pix_ce),
                .d_i     (flags_q),
                .q_o     (flags_dly)
            );
        end
    endgenerate

    assign vid_o.pix_ce      = pix_ce;
    assign vid_o.vga_clk     = vga_clk_q;
    assign vid_o.x           = hcnt_q;
    assign vid_o.y           = vcnt_q;
    // Held low while reset is asserted; otherwise the live active-area decode.
    assign vid_o.de          = de_now & rst_n_i;
    assign vid_o.line_start  = pix_ce && (hcnt_q == '0);
    assign vid_o.frame_start = pix_ce && (hcnt_q == '0) && (vcnt_q == '0);
    assign vid_o.hsync       = flags_dly.hs ^ ~SYNC_POL;
    assign vid_o.vsync       = flags_dly.vs ^ ~SYNC_POL;
    assign vid_o.blank_n     = flags_dly.de;
    assign vid_o.sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full 640x480 with no delay,
// a tiny raster with delay 3, a tiny raster with /4 divider and positive
// sync), compared each clock against a time-based raster model.
module tb_vga_timing_gen;

    localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_A = 6, SV_F = 1, SV_S = 2, SV_B = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int t        = 0;
    int n_assert = 0;
    int n_fail   = 0;
    bit tbl_on   = 1'b0;
    bit meas_on  = 1'b0;

    int hs_fall_a = -1;
    int hs_low_a  = 0;
    int de_clk_a  = 0;
    int vs_low_b  = 0;
    int de_lines_b = 0;
    int fs_b[$];
    int fs_c[$];

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen #(.PIPE_DLY(0)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .vid_o(if_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .CLK_DIV(2), .PIPE_DLY(3), .SYNC_POL(1'b0)
    ) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .vid_o(if_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .CLK_DIV(4), .PIPE_DLY(1), .SYNC_POL(1'b1)
    ) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .vid_o(if_c)
    );

    typedef struct {
        int tt;
        bit pce, vclk;
        int x, y;
        bit de, ls, fs, hs, bn;
    } vec_t;

    vec_t tbl[13];

    // Expected outputs tt clocks after reset release: pixel index is tt/cd,
    // position is that index folded into the raster; sync/blank show the
    // decode of the pixel dly earlier, and nothing before the first clock.
    function automatic logic [28:0] model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                          input int cd, dly, input bit pol,
                                          input int tt, input bit rst_now);
        int ht, vt, p, h, v, q, hq, vq;
        bit pce, vclk, de, ls, fs, hs_a, vs_a, bn;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        p    = tt / cd;
        h    = p % ht;
        v    = (p / ht) % vt;
        pce  = (tt % cd) == cd - 1;
        vclk = (tt % cd) >= cd / 2;
        de   = rst_now && (h < ha) && (v < va);
        ls   = pce && (h == 0);
        fs   = ls && (v == 0);
        hs_a = 1'b0;
        vs_a = 1'b0;
        bn   = 1'b0;
        q    = p - dly;
        if (tt >= 1 && q >= 0) begin
            hq   = q % ht;
            vq   = (q / ht) % vt;
            hs_a = (hq >= ha + hf) && (hq < ha + hf + hs);
            vs_a = (vq >= va + vf) && (vq < va + vf + vs);
            bn   = (hq < ha) && (vq < va);
        end
        return {pce, vclk, 10'(h), 10'(v), de, ls, fs,
                hs_a ? pol : ~pol, vs_a ? pol : ~pol, bn, 1'b0};
    endfunction

    function automatic logic [28:0] pk(input logic pce, vclk, input logic [9:0] x, y,
                                       input logic de, ls, fs, hs, vs, bn, sn);
        return {pce, vclk, x, y, de, ls, fs, hs, vs, bn, sn};
    endfunction

    task automatic cmp(input string name, input logic [28:0] act, input logic [28:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        cmp("dut_a", pk(if_a.pix_ce, if_a.vga_clk, if_a.x, if_a.y, if_a.de, if_a.line_start,
                        if_a.frame_start, if_a.hsync, if_a.vsync, if_a.blank_n, if_a.sync_n),
            model(640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 1'b0, t, rst_n));
        cmp("dut_b", pk(if_b.pix_ce, if_b.vga_clk, if_b.x, if_b.y, if_b.de, if_b.line_start,
                        if_b.frame_start, if_b.hsync, if_b.vsync, if_b.blank_n, if_b.sync_n),
            model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 2, 3, 1'b0, t, rst_n));
        cmp("dut_c", pk(if_c.pix_ce, if_c.vga_clk, if_c.x, if_c.y, if_c.de, if_c.line_start,
                        if_c.frame_start, if_c.hsync, if_c.vsync, if_c.blank_n, if_c.sync_n),
            model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 4, 1, 1'b1, t, rst_n));
        if (tbl_on) begin
            foreach (tbl[k]) begin
                if (tbl[k].tt == t) begin
                    cmp("tbl_a",
                        {3'b000, if_a.pix_ce, if_a.vga_clk, if_a.x, if_a.y, if_a.de,
                         if_a.line_start, if_a.frame_start, if_a.hsync, if_a.blank_n},
                        {3'b000, tbl[k].pce, tbl[k].vclk, 10'(tbl[k].x), 10'(tbl[k].y),
                         tbl[k].de, tbl[k].ls, tbl[k].fs, tbl[k].hs, tbl[k].bn});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) t = 0;
        else        t = t + 1;
        @(negedge clk);
        check_all();
        if (meas_on) begin
            if (hs_fall_a < 0 && !if_a.hsync) hs_fall_a = t;
            if (t >= 1600 && t < 3200) begin
                if (!if_a.hsync) hs_low_a++;
                if (if_a.de)     de_clk_a++;
            end
            if (if_b.frame_start) fs_b.push_back(t);
            if (if_c.frame_start) fs_c.push_back(t);
            if (fs_b.size() == 2) begin
                if (!if_b.vsync) vs_low_b++;
                if (if_b.line_start && if_b.de) de_lines_b++;
            end
        end
    endtask

    task automatic set_rst(input bit v);
        rst_n = v;
        #1;
        check_all();
    endtask

    // Pins that must all read as reset values: {pix_ce, vga_clk, x, y, hsync, vsync, blank_n}.
    task automatic chk_rst(input string name, input logic pce, vclk, input logic [9:0] x, y,
                           input logic hs, vs, bn);
        cmp(name, {4'b0000, pce, vclk, x, y, hs, vs, bn},
            {4'b0000, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int run_len;

        //            tt    pce vclk x    y  de ls fs hs bn
        tbl[0]  = '{    0, 0, 0,   0,  0, 1, 0, 0, 1, 0};
        tbl[1]  = '{    1, 1, 1,   0,  0, 1, 1, 1, 1, 1};
        tbl[2]  = '{    2, 0, 0,   1,  0, 1, 0, 0, 1, 1};
        tbl[3]  = '{    3, 1, 1,   1,  0, 1, 0, 0, 1, 1};
        tbl[4]  = '{ 1279, 1, 1, 639,  0, 1, 0, 0, 1, 1};
        tbl[5]  = '{ 1280, 0, 0, 640,  0, 0, 0, 0, 1, 0};
        tbl[6]  = '{ 1311, 1, 1, 655,  0, 0, 0, 0, 1, 0};
        tbl[7]  = '{ 1312, 0, 0, 656,  0, 0, 0, 0, 0, 0};
        tbl[8]  = '{ 1503, 1, 1, 751,  0, 0, 0, 0, 0, 0};
        tbl[9]  = '{ 1504, 0, 0, 752,  0, 0, 0, 0, 1, 0};
        tbl[10] = '{ 1599, 1, 1, 799,  0, 0, 0, 0, 1, 0};
        tbl[11] = '{ 1600, 0, 0,   0,  1, 1, 0, 0, 1, 1};
        tbl[12] = '{ 1601, 1, 1,   0,  1, 1, 1, 0, 1, 1};

        // Reset held for 10 clocks.
        rst_n = 1'b0;
        repeat (10) begin
            tick();
            chk_rst("reset_a", if_a.pix_ce, if_a.vga_clk, if_a.x, if_a.y,
                    if_a.hsync, if_a.vsync, if_a.blank_n);
        end

        // Release and run two full lines of the 640x480 raster.
        tbl_on  = 1'b1;
        meas_on = 1'b1;
        set_rst(1'b1);
        repeat (3300) tick();
        tbl_on  = 1'b0;
        meas_on = 1'b0;

        cmp_int("hsync_fall_cycle", hs_fall_a, 1312);
        cmp_int("hsync_low_clk_per_line", hs_low_a, 192);
        cmp_int("de_clk_per_line", de_clk_a, 1280);
        cmp_int("fs_b_count_ge3", int'(fs_b.size() >= 3), 1);
        cmp_int("fs_c_count_ge3", int'(fs_c.size() >= 3), 1);
        if (fs_b.size() >= 3) begin
            cmp_int("frame_period_b", fs_b[2] - fs_b[1], 330);
            cmp_int("vsync_low_clk_b", vs_low_b, 60);
            cmp_int("de_lines_b", de_lines_b, 6);
        end
        if (fs_c.size() >= 3) begin
            cmp_int("frame_period_c", fs_c[2] - fs_c[1], 660);
        end

        // Reset for one clock while u_b is inside hsync and vsync.
        n = 0;
        while (!(if_b.x == 10'd11 && if_b.y == 10'd8) && n < 400) begin
            tick();
            n++;
        end
        cmp_int("wait_b_position", int'(if_b.x == 10'd11 && if_b.y == 10'd8), 1);
        cmp_int("b_vsync_before_reset", int'(if_b.vsync), 0);
        rst_n = 1'b0;
        tick();
        set_rst(1'b1);
        chk_rst("midframe_rst_b", if_b.pix_ce, if_b.vga_clk, if_b.x, if_b.y,
                if_b.hsync, if_b.vsync, if_b.blank_n);
        chk_rst("midframe_rst_a", if_a.pix_ce, if_a.vga_clk, if_a.x, if_a.y,
                if_a.hsync, if_a.vsync, if_a.blank_n);
        repeat (1400) tick();

        // Random run lengths between random-length reset pulses.
        for (int s = 0; s < 12 && n_fail < 200; s++) begin
            run_len = int'($urandom_range(100, 3500));
            repeat (run_len) tick();
            rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
            set_rst(1'b1);
        end
        repeat (50) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
